// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO port responder.
// Holds the register offsets, the STATUS/CTRL bit positions and the encoding of
// the debounce FSM states. The top module and the debouncer both import it.
package mmio_pkg;

  // Word offsets within the 32-byte window (Address[4:2])
  localparam logic [2:0] OffPortOut  = 3'd0;
  localparam logic [2:0] OffPortIn   = 3'd1;
  localparam logic [2:0] OffStatus   = 3'd2;
  localparam logic [2:0] OffCtrl     = 3'd3;
  localparam logic [2:0] OffChgCount = 3'd4;

  // STATUS bits
  localparam int unsigned StatusChangeBit = 0;

  // CTRL bits
  localparam int unsigned CtrlIeBit      = 0;
  localparam int unsigned CtrlOutHoldBit = 1;

  // Debounce FSM encoding
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCount  = 2'd1,
    StCommit = 2'd2
  } deb_state_e;

endpackage

// File: rtl/port_debouncer.sv
// Input synchronizer and debounce FSM for the 8-bit switch port.
// The two-flop synchronizer feeds a stability counter. A new value is committed
// once it has been stable for DebounceCycles consecutive cycles.
//   clk_i      - clock
//   rst_ni     - asynchronous active-low reset
//   port_i     - raw asynchronous switch inputs
//   port_in_i  - currently accepted PORT_IN value (held in the top module)
//   commit_o   - one-cycle pulse: load PORT_IN from cand_o on this edge
//   cand_o     - candidate value being debounced
module port_debouncer
  import mmio_pkg::*;
#(
  parameter int unsigned DebounceCycles = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] port_i,
  input  logic [7:0] port_in_i,
  output logic       commit_o,
  output logic [7:0] cand_o
);

  localparam logic [7:0] DebCnt = 8'(DebounceCycles);

  logic [7:0] sync1_q, sync2_q;
  logic [7:0] cand_q, cand_d;
  logic [7:0] cnt_q, cnt_d;
  deb_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (sync2_q != port_in_i) begin
          cand_d  = sync2_q;
          cnt_d   = 8'd1;
          // With a one-cycle requirement the first stable sample already qualifies
          state_d = (DebCnt == 8'd1) ? StCommit : StCount;
        end
      end
      StCount: begin
        if (sync2_q == port_in_i) begin
          // Input bounced back to the accepted value: abandon the candidate
          state_d = StIdle;
          cnt_d   = 8'd0;
        end else begin
          if (sync2_q == cand_q) begin
            cnt_d = cnt_q + 8'd1;
          end else begin
            cand_d = sync2_q;
            cnt_d  = 8'd1;
          end
          state_d = (cnt_d == DebCnt) ? StCommit : StCount;
        end
      end
      StCommit: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 8'd0;
      sync2_q <= 8'd0;
      cand_q  <= 8'd0;
      cnt_q   <= 8'd0;
      state_q <= StIdle;
    end else begin
      sync1_q <= port_i;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign commit_o = (state_q == StCommit);
  assign cand_o   = cand_q;

endmodule

// File: rtl/mmio_port_responder.sv
// Memory-mapped I/O port responder: a 32-byte register window holding an output
// port, a debounced input port, a change flag with interrupt, control bits and
// a change counter.
//   clk        - clock
//   reset      - asynchronous active-low reset
//   Address    - byte address; Address[4:2] selects the register
//   WriteData  - store data
//   MemWrite   - store strobe
//   MemRead    - load strobe
//   PortIn     - raw switch inputs
//   ReadData   - combinational load data (0 when not a hit read)
//   Hit        - Address falls inside the window
//   PortOut    - PORT_OUT register
//   Irq        - registered CHANGE & IE
module mmio_port_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS    = 32'hFFFF_0000,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [7:0]  PortIn,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic [31:0] PortOut,
  output logic        Irq
);

  logic [2:0]  offset;
  logic        wr_en;
  logic        commit;
  logic [7:0]  cand;

  logic [31:0] port_out_q, port_out_d;
  logic [7:0]  port_in_q, port_in_d;
  logic        change_q, change_d;
  logic        ie_q, ie_d;
  logic        hold_q, hold_d;
  logic [15:0] chg_count_q, chg_count_d;
  logic        irq_q;

  // Byte lanes are not decoded; only word accesses are meaningful
  logic unused_addr_bits;
  assign unused_addr_bits = ^Address[1:0];

  assign Hit    = (Address[31:5] == BASE_ADDRESS[31:5]);
  assign offset = Address[4:2];
  assign wr_en  = Hit & MemWrite;

  port_debouncer #(
    .DebounceCycles(DEBOUNCE_CYCLES)
  ) u_port_debouncer (
    .clk_i    (clk),
    .rst_ni   (reset),
    .port_i   (PortIn),
    .port_in_i(port_in_q),
    .commit_o (commit),
    .cand_o   (cand)
  );

  always_comb begin
    port_out_d  = port_out_q;
    port_in_d   = port_in_q;
    change_d    = change_q;
    ie_d        = ie_q;
    hold_d      = hold_q;
    chg_count_d = chg_count_q;

    if (wr_en) begin
      case (offset)
        OffPortOut: if (!hold_q) port_out_d = WriteData;
        OffStatus:  if (WriteData[StatusChangeBit]) change_d = 1'b0;
        OffCtrl: begin
          ie_d   = WriteData[CtrlIeBit];
          hold_d = WriteData[CtrlOutHoldBit];
        end
        default: ;
      endcase
    end

    // Applied after the W1C so a commit in the same cycle keeps CHANGE set
    if (commit) begin
      port_in_d   = cand;
      change_d    = 1'b1;
      chg_count_d = chg_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_out_q  <= 32'd0;
      port_in_q   <= 8'd0;
      change_q    <= 1'b0;
      ie_q        <= 1'b0;
      hold_q      <= 1'b0;
      chg_count_q <= 16'd0;
      irq_q       <= 1'b0;
    end else begin
      port_out_q  <= port_out_d;
      port_in_q   <= port_in_d;
      change_q    <= change_d;
      ie_q        <= ie_d;
      hold_q      <= hold_d;
      chg_count_q <= chg_count_d;
      irq_q       <= change_q & ie_q;
    end
  end

  // Reads use current register state, so a same-cycle store is not yet visible
  always_comb begin
    ReadData = 32'd0;
    if (Hit && MemRead) begin
      case (offset)
        OffPortOut:  ReadData = port_out_q;
        OffPortIn:   ReadData = {24'd0, port_in_q};
        OffStatus:   ReadData = {31'd0, change_q};
        OffCtrl:     ReadData = {30'd0, hold_q, ie_q};
        OffChgCount: ReadData = {16'd0, chg_count_q};
        default:     ReadData = 32'd0;
      endcase
    end
  end

  assign PortOut = port_out_q;
  assign Irq     = irq_q;

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed self-checking bench for mmio_port_responder (default parameters).
module tb_mmio_port_responder;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [7:0]  PortIn;
  logic [31:0] ReadData;
  logic        Hit;
  logic [31:0] PortOut;
  logic        Irq;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] APortOut = 32'hFFFF_0000;
  localparam logic [31:0] APortIn  = 32'hFFFF_0004;
  localparam logic [31:0] AStatus  = 32'hFFFF_0008;
  localparam logic [31:0] ACtrl    = 32'hFFFF_000C;
  localparam logic [31:0] AChg     = 32'hFFFF_0010;

  mmio_port_responder dut (
    .clk      (clk),
    .reset    (reset),
    .Address  (Address),
    .WriteData(WriteData),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .PortIn   (PortIn),
    .ReadData (ReadData),
    .Hit      (Hit),
    .PortOut  (PortOut),
    .Irq      (Irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address   = a;
    WriteData = d;
    MemWrite  = 1'b1;
    tick();
    MemWrite  = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    Address = a;
    MemRead = 1'b1;
    #1;
    chk(tag, ReadData, exp);
    MemRead = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    Address   = 32'd0;
    WriteData = 32'd0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    PortIn    = 8'h00;

    // Reset state
    #1;
    chk("rst_portout", PortOut, 32'd0);
    chk("rst_irq", {31'd0, Irq}, 32'd0);
    chk("miss_hit_addr0", {31'd0, Hit}, 32'd0);
    rd("rst_port_in", APortIn, 32'd0);
    rd("rst_status", AStatus, 32'd0);
    rd("rst_ctrl", ACtrl, 32'd0);
    rd("rst_chg", AChg, 32'd0);
    #6;
    reset = 1'b1;
    tick();

    // Store/load PORT_OUT; byte offset bits ignored
    wr(APortOut, 32'hDEAD_BEEF);
    chk("portout_store", PortOut, 32'hDEAD_BEEF);
    rd("portout_load", APortOut, 32'hDEAD_BEEF);
    rd("portout_load_unaligned", 32'hFFFF_0003, 32'hDEAD_BEEF);
    Address = APortOut;
    #1;
    chk("no_read_strobe_zero", ReadData, 32'd0);

    // Enable interrupt
    wr(ACtrl, 32'h1);
    rd("ctrl_ie", ACtrl, 32'h1);

    // Debounce 0x00 -> 0x5A: accepted on the 7th edge, Irq one edge later
    PortIn = 8'h5A;
    ticks(6);
    rd("deb_not_yet", APortIn, 32'd0);
    tick();
    rd("deb_port_in", APortIn, 32'h5A);
    rd("deb_status", AStatus, 32'h1);
    rd("deb_chg", AChg, 32'h1);
    chk("deb_irq_lag", {31'd0, Irq}, 32'd0);
    tick();
    chk("deb_irq", {31'd0, Irq}, 32'd1);

    // W1C clears CHANGE; Irq follows one edge later
    wr(AStatus, 32'h1);
    rd("w1c_status", AStatus, 32'd0);
    chk("w1c_irq_lag", {31'd0, Irq}, 32'd1);
    tick();
    chk("w1c_irq", {31'd0, Irq}, 32'd0);

    // Bouncing input never qualifies
    for (int i = 0; i < 10; i++) begin
      PortIn = 8'h00;
      ticks(2);
      PortIn = 8'h5A;
      ticks(2);
    end
    ticks(8);
    rd("bounce_port_in", APortIn, 32'h5A);
    rd("bounce_status", AStatus, 32'd0);
    rd("bounce_chg", AChg, 32'h1);
    chk("bounce_irq", {31'd0, Irq}, 32'd0);

    // Unmapped offsets and out-of-window addresses
    Address = 32'hFFFF_0014;
    #1;
    chk("hit_off5", {31'd0, Hit}, 32'd1);
    rd("read_off5", 32'hFFFF_0014, 32'd0);
    rd("read_off7", 32'hFFFF_001C, 32'd0);
    Address = 32'hFFFF_0020;
    #1;
    chk("miss_0020", {31'd0, Hit}, 32'd0);
    rd("read_0020", 32'hFFFF_0020, 32'd0);
    wr(32'hFFFF_0020, 32'h0);
    chk("miss_store_ignored", PortOut, 32'hDEAD_BEEF);
    wr(APortIn, 32'hFF);
    rd("ro_port_in", APortIn, 32'h5A);
    wr(AChg, 32'h77);
    rd("ro_chg", AChg, 32'h1);

    // Simultaneous read and write returns the old value
    Address   = APortOut;
    WriteData = 32'h1111_2222;
    MemWrite  = 1'b1;
    MemRead   = 1'b1;
    #1;
    chk("rw_same_pre", ReadData, 32'hDEAD_BEEF);
    tick();
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    chk("rw_same_post", PortOut, 32'h1111_2222);

    // OUT_HOLD blocks PORT_OUT stores
    wr(ACtrl, 32'h3);
    rd("ctrl_hold", ACtrl, 32'h3);
    wr(APortOut, 32'h1234);
    chk("hold_portout", PortOut, 32'h1111_2222);

    // W1C landing on the commit edge: set wins
    PortIn = 8'h00;
    ticks(6);
    Address   = AStatus;
    WriteData = 32'h1;
    MemWrite  = 1'b1;
    tick();
    MemWrite = 1'b0;
    rd("setwins_status", AStatus, 32'h1);
    rd("setwins_port_in", APortIn, 32'h0);
    rd("setwins_chg", AChg, 32'h2);
    tick();
    chk("setwins_irq", {31'd0, Irq}, 32'd1);

    // Reset during COUNT
    wr(ACtrl, 32'h1);
    wr(APortOut, 32'hFF);
    chk("pre_rst_portout", PortOut, 32'hFF);
    chk("pre_rst_irq", {31'd0, Irq}, 32'd1);
    PortIn = 8'h33;
    ticks(4);
    reset = 1'b0;
    #1;
    chk("mid_rst_portout", PortOut, 32'd0);
    chk("mid_rst_irq", {31'd0, Irq}, 32'd0);
    rd("mid_rst_status", AStatus, 32'd0);
    rd("mid_rst_ctrl", ACtrl, 32'd0);
    rd("mid_rst_chg", AChg, 32'd0);
    rd("mid_rst_port_in", APortIn, 32'd0);
    PortIn = 8'h00;
    reset  = 1'b1;
    ticks(10);
    rd("post_rst_status", AStatus, 32'd0);
    rd("post_rst_port_in", APortIn, 32'd0);
    rd("post_rst_chg", AChg, 32'd0);
    chk("post_rst_irq", {31'd0, Irq}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_port_responder.md
MMIO_PORT_RESPONDER -- requirements
Module: mmio_port_responder

Interface
REQ-001 Parameter BASE_ADDRESS, default 32'hFFFF_0000, is the word-aligned base of the 32-byte register window.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive stable cycles (1..255) required before PortIn is accepted.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 Address  input  32  byte address from the processor data path.
REQ-006 WriteData  input  32  store data.
REQ-007 MemWrite  input  1  store strobe, one cycle per store.
REQ-008 MemRead  input  1  load strobe.
REQ-009 PortIn  input  8  asynchronous external switch inputs.
REQ-010 ReadData  output  32  load data.
REQ-011 Hit  output  1  high when Address is inside the window.
REQ-012 PortOut  output  32  registered output port.
REQ-013 Irq  output  1  change interrupt request.

Function
REQ-014 Hit SHALL be 1 when Address[31:5] equals BASE_ADDRESS[31:5]; Address[1:0] is ignored; offset = Address[4:2].
REQ-015 Registers SHALL be: 0 PORT_OUT (RW, 32b); 1 PORT_IN (RO, debounced, zero-extended); 2 STATUS (bit0 CHANGE, write-1-to-clear); 3 CTRL (bit0 IE, bit1 OUT_HOLD, RW); 4 CHG_COUNT (RO, 16b, zero-extended, wraps 0xFFFF->0); offsets 5-7 read 0.
REQ-016 ReadData SHALL be combinational: selected register when Hit&MemRead, else 0.
REQ-017 A write SHALL take effect only on the rising edge where Hit&MemWrite; writes to RO or unmapped offsets SHALL be ignored.
REQ-018 PortOut SHALL equal the PORT_OUT register; a write to PORT_OUT while OUT_HOLD=1 SHALL be ignored.
REQ-019 PortIn SHALL pass through a 2-flop synchronizer; sync value is valid 2 edges after the pin changes.
REQ-020 Debounce FSM states: IDLE (sync == PORT_IN), COUNT (sync != PORT_IN, counter runs), COMMIT (one cycle).
REQ-021 IDLE->COUNT when sync differs from PORT_IN; counter loads 1 and latches candidate value.
REQ-022 In COUNT, sync == candidate increments the counter; sync != candidate reloads candidate and counter to 1; sync == PORT_IN returns to IDLE.
REQ-023 COUNT->COMMIT when counter reaches DEBOUNCE_CYCLES; COMMIT loads PORT_IN with candidate, sets CHANGE, increments CHG_COUNT, then returns to IDLE.
REQ-024 If COMMIT and a W1C of CHANGE occur in the same cycle, set SHALL win.
REQ-025 Irq SHALL be registered: Irq = CHANGE & IE, one cycle after either changes.
REQ-026 Simultaneous MemRead and MemWrite to the same register: ReadData SHALL return the pre-write value.

Reset
REQ-027 On reset low, asynchronously: PORT_OUT=0, PORT_IN=0, synchronizer=0, candidate=0, counter=0, state=IDLE, CHANGE=0, CTRL=0, CHG_COUNT=0, Irq=0.
REQ-028 Reset asserted mid-debounce SHALL discard the candidate with no CHANGE set; the first edge after release SHALL behave as from IDLE.

Structure
REQ-029 Register offsets, STATUS/CTRL bit positions, and FSM state encodings SHALL reside in a shared package mmio_pkg.
REQ-030 The synchronizer and debounce FSM SHALL be one sub-module, port_debouncer; decode, registers and Irq stay in the top module.

Verification
REQ-031 Store 0xDEAD_BEEF to 0xFFFF_0000, then load -> PortOut=0xDEADBEEF next edge; ReadData=0xDEADBEEF.
REQ-032 PortIn 0x00->0x5A held -> PORT_IN=0x5A after 2+4+1 edges; STATUS=1; CHG_COUNT=1; Irq=1 one cycle later if IE=1.
REQ-033 PortIn toggles 0x5A/0x00 every 2 cycles for 40 cycles -> PORT_IN unchanged; CHANGE=0; CHG_COUNT unchanged.
REQ-034 Set CTRL=0x3, store 0x1234 to PORT_OUT -> PortOut unchanged; W1C STATUS in the commit cycle -> CHANGE stays 1.
REQ-035 Load from 0xFFFF_0014 and from 0xFFFF_0020 -> ReadData=0; Hit=1 then 0; store to PORT_IN offset -> no effect.
REQ-036 Assert reset during COUNT with PORT_OUT=0xFF -> all registers 0, Irq=0, no CHANGE after release with PortIn=0.
